// File: rtl/ips2l_uart_cmd_seq_32bit_if.sv
// ips2l_uart_cmd_seq_32bit_if: UART byte ports and register-bank command bus for the command sequencer.
// Ports (master = sequencer side):
//   rx_data/rx_valid            received byte strobe (in)
//   tx_data/tx_valid/tx_ready   transmit byte handshake (out/out/in)
//   addr/data/we/cmd_en         bank command, cmd_en is a one-cycle strobe (out)
//   cmd_done/rd_data            bank completion and read data (in)
//   rd_space                    bank fifo_data_valid, high while waiting on a read (out)
//   busy/err_cnt                status: not idle, saturating error count (out)
interface ips2l_uart_cmd_seq_32bit_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        we;
  logic        cmd_en;
  logic        cmd_done;
  logic [31:0] rd_data;
  logic        rd_space;
  logic        busy;
  logic [7:0]  err_cnt;
  modport master (
    input  rx_data, rx_valid, tx_ready, cmd_done, rd_data,
    output tx_data, tx_valid, addr, data, we, cmd_en, rd_space, busy, err_cnt
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, cmd_done, rd_data,
    input  tx_data, tx_valid, addr, data, we, cmd_en, rd_space, busy, err_cnt
  );
endinterface

// File: rtl/ips2l_uart_cmd_seq_32bit.sv
// ips2l_uart_cmd_seq_32bit: byte-stream command sequencer between UART rx/tx and the 32-bit register bank.
// Ports: clk, rst_n (async active-low), bus (ips2l_uart_cmd_seq_32bit_if.master).
// Frames: write = 57,addr,d3,d2,d1,d0 ; read = 52,addr. Responses: 4B (write ok), 4 data bytes (read ok), 45 (error).
// Optional feature: define UART_CMD_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module ips2l_uart_cmd_seq_32bit #(
  parameter logic [15:0] CMD_TIMEOUT = 16'd4096,
  parameter logic [15:0] FRAME_GAP   = 16'd50000
) (
  input logic                       clk,
  input logic                       rst_n,
  ips2l_uart_cmd_seq_32bit_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHK, S_ISSUE, S_WAIT, S_RESP} state_t;
`ifdef UART_CMD_CHKSUM_EN
  localparam state_t FRAME_END = S_CHK;
  logic [7:0] r_chk;
`else
  localparam state_t FRAME_END = S_ISSUE;
`endif
  state_t      r_state;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [31:0] r_rd;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_err_cnt;
  logic        w_op_ok;
  logic        w_gap_hit;
  logic        w_tmo;
  logic        w_err;
  // r_cnt is shared: frame-gap counter in ADDR/DATA/CHK, command timeout counter in WAIT.
  always_comb begin
    w_op_ok   = bus.rx_data == 8'h57 || bus.rx_data == 8'h52;
    w_gap_hit = (r_state inside {S_ADDR, S_DATA, S_CHK}) && !bus.rx_valid && r_cnt == FRAME_GAP - 16'd1;
    w_tmo     = r_state == S_WAIT && !bus.cmd_done && r_cnt == CMD_TIMEOUT - 16'd1;
    w_err     = w_gap_hit || w_tmo ||
                (bus.rx_valid && (r_state inside {S_ISSUE, S_WAIT, S_RESP})) ||
                (bus.rx_valid && r_state == S_IDLE && !w_op_ok);
`ifdef UART_CMD_CHKSUM_EN
    w_err     = w_err || (bus.rx_valid && r_state == S_CHK && bus.rx_data != r_chk);
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err_cnt  <= '0;
`ifdef UART_CMD_CHKSUM_EN
      r_chk      <= '0;
`endif
    end else begin
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      case (r_state)
        S_IDLE: if (bus.rx_valid && w_op_ok) begin
          r_we    <= bus.rx_data == 8'h57;
          r_cnt   <= '0;
          r_state <= S_ADDR;
`ifdef UART_CMD_CHKSUM_EN
          r_chk   <= bus.rx_data;
`endif
        end
        S_ADDR: if (bus.rx_valid) begin
          r_addr  <= bus.rx_data;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= r_we ? S_DATA : FRAME_END;
`ifdef UART_CMD_CHKSUM_EN
          r_chk   <= r_chk ^ bus.rx_data;
`endif
        end else if (w_gap_hit) r_state <= S_IDLE;
        else r_cnt <= r_cnt + 16'd1;
        S_DATA: if (bus.rx_valid) begin
          r_data  <= {r_data[23:0], bus.rx_data};
          r_idx   <= r_idx + 2'd1;
          r_cnt   <= '0;
          r_state <= r_idx == 2'd3 ? FRAME_END : S_DATA;
`ifdef UART_CMD_CHKSUM_EN
          r_chk   <= r_chk ^ bus.rx_data;
`endif
        end else if (w_gap_hit) r_state <= S_IDLE;
        else r_cnt <= r_cnt + 16'd1;
`ifdef UART_CMD_CHKSUM_EN
        S_CHK: if (bus.rx_valid) begin
          r_tx_data  <= 8'h45;
          r_idx      <= '0;
          r_tx_valid <= bus.rx_data != r_chk;
          r_state    <= bus.rx_data == r_chk ? S_ISSUE : S_RESP;
        end else if (w_gap_hit) r_state <= S_IDLE;
        else r_cnt <= r_cnt + 16'd1;
`endif
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (bus.cmd_done) begin
          r_rd       <= bus.rd_data;
          r_tx_data  <= r_we ? 8'h4B : bus.rd_data[31:24];
          r_idx      <= r_we ? 2'd0 : 2'd3;
          r_tx_valid <= 1'b1;
          r_state    <= S_RESP;
        end else if (w_tmo) begin
          r_tx_data  <= 8'h45;
          r_idx      <= '0;
          r_tx_valid <= 1'b1;
          r_state    <= S_RESP;
        end else r_cnt <= r_cnt + 16'd1;
        // r_idx counts bytes still to send after the one on tx_data.
        S_RESP: if (bus.tx_ready) begin
          if (r_idx == 2'd0) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tx_data <= r_rd[23:16];
            r_rd      <= r_rd << 8;
            r_idx     <= r_idx - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.addr     = r_addr;
  assign bus.data     = r_data;
  assign bus.we       = r_we;
  assign bus.cmd_en   = r_state == S_ISSUE;
  assign bus.rd_space = r_state == S_WAIT && !r_we;
  assign bus.busy     = r_state != S_IDLE;
  assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_ips2l_uart_cmd_seq_32bit.sv
// tb_ips2l_uart_cmd_seq_32bit: directed and randomized frames against a frame-level reference model.
module tb_ips2l_uart_cmd_seq_32bit;
  localparam logic [15:0] TMO = 16'd40;
  localparam logic [15:0] GAP = 16'd60;
  typedef logic [7:0] u8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ips2l_uart_cmd_seq_32bit_if bus();
  ips2l_uart_cmd_seq_32bit #(.CMD_TIMEOUT(TMO), .FRAME_GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_err = 0;
  int n_cmd = 0;
  int done_cd = 0;
  int bank_delay = 1;
  int ready_pct = 100;
  int cmd_cyc = 0;
  int txv_cyc = 0;
  logic txv_prev = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_tx = '0;
  logic [7:0] cmd_addr;
  logic [31:0] cmd_data;
  logic cmd_we;
  logic rd_space_seen;
  logic [31:0] bank_mem [256];
  logic [31:0] ref_mem [256];
  u8 tx_q[$];
  u8 exp_q[$];
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Bank model and tx sink, all acting on the falling edge.
  always @(negedge clk) begin
    bus.cmd_done = 1'b0;
    if (!rst_n) done_cd = 0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        bus.cmd_done = 1'b1;
        bus.rd_data = bank_mem[bus.addr];
        rd_space_seen = bus.rd_space;
      end
    end
    if (bus.cmd_en) begin
      n_cmd++;
      cmd_addr = bus.addr;
      cmd_data = bus.data;
      cmd_we = bus.we;
      cmd_cyc = cyc;
      if (bus.we) bank_mem[bus.addr] = bus.data;
      done_cd = bank_delay;
    end
    if (prev_stall) check("tx_hold", 64'(bus.tx_data), 64'(prev_tx));
    if (bus.tx_valid && !txv_prev) txv_cyc = cyc;
    txv_prev = bus.tx_valid;
    bus.tx_ready = $urandom_range(99) < ready_pct;
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_tx = bus.tx_data;
  end
  function automatic logic [63:0] q2v(input u8 q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v = (v << 8) | 64'(q[i]);
    v[63:56] = 8'(q.size());
    return v;
  endfunction
  function automatic logic [63:0] outs();
    return {3'b0, bus.tx_valid, bus.tx_data, bus.addr, bus.data, bus.we, bus.cmd_en, bus.rd_space, bus.busy, bus.err_cnt};
  endfunction
  task automatic bump();
    exp_err = exp_err >= 255 ? 255 : exp_err + 1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input u8 b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask
  task automatic send_raw(input u8 q[$]);
    foreach (q[i]) begin
      if (i > 0) tick($urandom_range(3));
      send(q[i]);
    end
  endtask
  task automatic send_frame(input logic w, input u8 a, input logic [31:0] d);
    u8 q[$];
    u8 x;
    q = w ? '{8'h57, a, d[31:24], d[23:16], d[15:8], d[7:0]} : '{8'h52, a};
`ifdef UART_CMD_CHKSUM_EN
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`else
    x = 8'h00;
`endif
    send_raw(q);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask
  // One complete command: delay 0 means the bank never answers.
  task automatic txn(input string tag, input logic w, input u8 a, input logic [31:0] d, input int delay, input logic stray);
    int c0 = n_cmd;
    tx_q.delete();
    exp_q.delete();
    bank_delay = delay;
    rd_space_seen = 1'bx;
    if (delay == 0) begin
      exp_q.push_back(8'h45);
      bump();
    end else if (w) begin
      exp_q.push_back(8'h4B);
      ref_mem[a] = d;
    end else for (int i = 3; i >= 0; i--) exp_q.push_back(ref_mem[a][i*8 +: 8]);
    send_frame(w, a, d);
    check({tag, "_lat"}, 64'(bus.cmd_en), 64'd1);
    if (stray) begin
      send(8'hAA);
      bump();
    end
    wait_idle(tag);
    check({tag, "_ncmd"}, 64'(n_cmd - c0), 64'd1);
    check({tag, "_addr"}, 64'(cmd_addr), 64'(a));
    check({tag, "_we"}, 64'(cmd_we), 64'(w));
    if (w) check({tag, "_data"}, 64'(cmd_data), 64'(d));
    if (delay != 0) check({tag, "_rdsp"}, 64'(rd_space_seen), 64'(!w));
    check({tag, "_resp_time"}, 64'(txv_cyc - cmd_cyc), 64'(delay == 0 ? int'(TMO) + 1 : delay + 1));
    check({tag, "_tx"}, q2v(tx_q), q2v(exp_q));
    check({tag, "_err"}, 64'(bus.err_cnt), 64'(exp_err));
  endtask
  initial begin
    int c0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.cmd_done = 1'b0;
    bus.rd_data = '0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bank_mem[i] = $urandom;
      ref_mem[i] = bank_mem[i];
    end
    tick(3);
    check("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    tick(2);
    ready_pct = 100;
    txn("t1_write", 1'b1, 8'h03, 32'h12345678, 3, 1'b0);
    bank_mem[8'hFF] = 32'h20200729;
    ref_mem[8'hFF] = 32'h20200729;
    ready_pct = 40;
    txn("t2_read", 1'b0, 8'hFF, 32'h0, 4, 1'b0);
    ready_pct = 80;
    txn("t3_timeout", 1'b0, 8'h05, 32'h0, 0, 1'b0);
    txn("done_vs_tmo", 1'b1, 8'h07, 32'hCAFEF00D, int'(TMO), 1'b0);
    // Stray byte landing on the exact timeout cycle must count once.
    tx_q.delete();
    bank_delay = 0;
    send_frame(1'b0, 8'h09, 32'h0);
    tick(int'(TMO));
    send(8'h33);
    bump();
    wait_idle("dual");
    check("dual_tx", q2v(tx_q), q2v('{8'h45}));
    check("dual_err", 64'(bus.err_cnt), 64'(exp_err));
    // Bad opcode then a partial frame left to expire.
    tx_q.delete();
    c0 = n_cmd;
    send(8'h00);
    bump();
    tick(1);
    check("t4_badop_err", 64'(bus.err_cnt), 64'(exp_err));
    send(8'h57);
    send(8'h01);
    tick(int'(GAP) - 1);
    check("t4_gap_early", 64'(bus.busy), 64'd1);
    check("t4_gap_early_err", 64'(bus.err_cnt), 64'(exp_err));
    tick(1);
    bump();
    check("t4_gap_busy", 64'(bus.busy), 64'd0);
    check("t4_gap_err", 64'(bus.err_cnt), 64'(exp_err));
    check("t4_ncmd", 64'(n_cmd - c0), 64'd0);
    check("t4_tx", q2v(tx_q), q2v('{}));
    txn("t4_after", 1'b0, 8'h01, 32'h0, 2, 1'b0);
`ifdef UART_CMD_CHKSUM_EN
    txn("t6_chk_ok", 1'b0, 8'h0A, 32'h0, 2, 1'b0);
    tx_q.delete();
    c0 = n_cmd;
    send_raw('{8'h52, 8'h0A, 8'h00});
    bump();
    wait_idle("t6_bad");
    check("t6_bad_ncmd", 64'(n_cmd - c0), 64'd0);
    check("t6_bad_tx", q2v(tx_q), q2v('{8'h45}));
    check("t6_bad_err", 64'(bus.err_cnt), 64'(exp_err));
`endif
    for (int k = 0; k < 14; k++) begin
      logic w;
      w = 1'($urandom);
      ready_pct = $urandom_range(30, 100);
      if ($urandom_range(3) == 0) begin
        send(8'($urandom_range(8'h51)));
        bump();
      end
      txn("rand", w, 8'($urandom_range(7)), $urandom, $urandom_range(7) == 0 ? 0 : $urandom_range(1, 12), $urandom_range(3) == 0);
    end
    // Reset while waiting on a read: everything clears and a late cmd_done is ignored.
    tx_q.delete();
    bank_delay = 0;
    send_frame(1'b0, 8'h05, 32'h0);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_outs", outs(), 64'd0);
    rst_n = 1'b1;
    exp_err = 0;
    @(posedge clk);
    done_cd = 2;
    tick(10);
    check("t5_outs", outs(), 64'd0);
    check("t5_tx", q2v(tx_q), q2v('{}));
    for (int i = 0; i < 260; i++) begin
      send(8'h00);
      bump();
    end
    tick(1);
    check("err_sat", 64'(bus.err_cnt), 64'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
